// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: forwards CPU bus traffic, and on a write to the trigger register it stalls
// the CPU and copies one page of memory into the PPU OAM data port.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_mem_addr,
    input  logic [7:0]  cpu_mem_data_out,
    input  logic        cpu_mem_write_en,
    input  logic        cpu_mem_read_en,
    output logic        cpu_stall,
    output logic        dma_active,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_write_en,
    output logic        bus_read_en,
    input  logic [7:0]  bus_data_in
);

    localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  page;
    logic [7:0]  page_nxt;
    logic [7:0]  idx;
    logic [7:0]  idx_nxt;
    logic        parity;
    logic        skip_done;
    logic        skip_nxt;
    logic [15:0] last_addr;

    always_comb begin
        state_nxt    = state;
        page_nxt     = page;
        idx_nxt      = idx;
        skip_nxt     = skip_done;
        bus_addr     = last_addr;
        bus_data_out = 8'h00;
        bus_write_en = 1'b0;
        bus_read_en  = 1'b0;

        case (state)
            IDLE: begin
                // The trigger write itself still reaches the bus.
                bus_addr     = cpu_mem_addr;
                bus_data_out = cpu_mem_data_out;
                bus_write_en = cpu_mem_write_en;
                bus_read_en  = cpu_mem_read_en;
                if (cpu_mem_write_en && (cpu_mem_addr == DMA_REG_ADDR)) begin
                    page_nxt  = cpu_mem_data_out;
                    idx_nxt   = 8'h00;
                    skip_nxt  = 1'b0;
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                // An odd-parity first ALIGN cycle costs one extra dummy cycle.
                if (parity && !skip_done) begin
                    skip_nxt = 1'b1;
                end else begin
                    skip_nxt  = 1'b0;
                    state_nxt = READ;
                end
            end
            READ: begin
                bus_addr    = {page, idx};
                bus_read_en = 1'b1;
                state_nxt   = WRITE;
            end
            WRITE: begin
                bus_addr     = OAM_DATA_ADDR;
                bus_write_en = 1'b1;
                bus_data_out = bus_data_in;
                if (idx == IDX_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = READ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            page       <= 8'h00;
            idx        <= 8'h00;
            parity     <= 1'b0;
            skip_done  <= 1'b0;
            cpu_stall  <= 1'b0;
            dma_active <= 1'b0;
            last_addr  <= 16'h0000;
        end else begin
            state      <= state_nxt;
            page       <= page_nxt;
            idx        <= idx_nxt;
            parity     <= ~parity;
            skip_done  <= skip_nxt;
            // Registered off next state, so both track state != IDLE exactly.
            cpu_stall  <= (state_nxt != IDLE);
            dma_active <= (state_nxt != IDLE);
            if ((state == READ) || (state == WRITE)) begin
                last_addr <= bus_addr;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: memory model on the system bus, scoreboard of expected
// DMA read addresses and OAM write data, stall/align length checks against a parity model.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_mem_addr;
    logic [7:0]  cpu_mem_data_out;
    logic        cpu_mem_write_en;
    logic        cpu_mem_read_en;
    logic        cpu_stall;
    logic        dma_active;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [7:0]  bus_data_in;

    oam_dma_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_mem_addr     (cpu_mem_addr),
        .cpu_mem_data_out (cpu_mem_data_out),
        .cpu_mem_write_en (cpu_mem_write_en),
        .cpu_mem_read_en  (cpu_mem_read_en),
        .cpu_stall        (cpu_stall),
        .dma_active       (dma_active),
        .bus_addr         (bus_addr),
        .bus_data_out     (bus_data_out),
        .bus_write_en     (bus_write_en),
        .bus_read_en      (bus_read_en),
        .bus_data_in      (bus_data_in)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- memory model ----------------
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus_read_en)  bus_data_in    <= mem[bus_addr];
        if (bus_write_en) mem[bus_addr]  <= bus_data_out;
    end

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic [15:0] exp_addr_q[$];
    int          vectors;
    int          miscompares;
    int          stall_cnt;
    int          align_cnt;
    int          wr_cnt;
    logic [15:0] last_rd;
    logic        saw_zero_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_stall) stall_cnt++;
        if (dma_active && !bus_read_en && !bus_write_en) align_cnt++;
        if (dma_active && bus_read_en) begin
            last_rd = bus_addr;
            if (bus_addr == 16'h0000) saw_zero_rd = 1'b1;
            if (exp_addr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL rd_addr observed=%0h expected=none", bus_addr);
            end else begin
                chk("rd_addr", {16'h0, bus_addr}, {16'h0, exp_addr_q.pop_front()});
            end
        end
        if (dma_active && bus_write_en) begin
            wr_cnt++;
            chk("wr_addr", {16'h0, bus_addr}, 32'h2004);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL wr_data observed=%0h expected=none", bus_data_out);
            end else begin
                chk("wr_data", {24'h0, bus_data_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_idle();
        cpu_mem_addr     = 16'h0000;
        cpu_mem_data_out = 8'h00;
        cpu_mem_write_en = 1'b0;
        cpu_mem_read_en  = 1'b0;
    endtask

    // Triggers a transfer so that the first ALIGN cycle sees the given parity.
    task automatic trigger(input logic [7:0] page, input int align_par, output int exp_align);
        while (((cyc + 1) & 1) != align_par) step();
        stall_cnt   = 0;
        align_cnt   = 0;
        wr_cnt      = 0;
        saw_zero_rd = 1'b0;
        for (int i = 0; i < 256; i++) begin
            exp_addr_q.push_back({page, 8'(i)});
            exp_q.push_back(mem[{page, 8'(i)}]);
        end
        exp_align        = 1 + align_par;
        cpu_mem_addr     = 16'h4014;
        cpu_mem_data_out = page;
        cpu_mem_write_en = 1'b1;
        #1;
        chk("trig_pass_we", {31'h0, bus_write_en}, 32'h1);
        chk("trig_pass_addr", {16'h0, bus_addr}, 32'h4014);
        step();
        cpu_idle();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!cpu_stall && n < 4) begin step(); n++; end
        chk("stall_rise", {31'h0, cpu_stall}, 32'h1);
        n = 0;
        while (cpu_stall && n < 800) begin step(); n++; end
        chk("stall_fall", {31'h0, cpu_stall}, 32'h0);
        chk("active_fall", {31'h0, dma_active}, 32'h0);
        step();
    endtask

    task automatic check_xfer(input string tag, input int exp_align);
        chk({tag, "_align"}, align_cnt, exp_align);
        // Window from the trigger cycle through the last WRITE.
        chk({tag, "_window"}, stall_cnt + 1, 1 + exp_align + 512);
        chk({tag, "_writes"}, wr_cnt, 256);
        chk({tag, "_exp_empty"}, exp_q.size() + exp_addr_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    int ea;
    initial begin
        vectors     = 0;
        miscompares = 0;
        stall_cnt   = 0;
        align_cnt   = 0;
        wr_cnt      = 0;
        saw_zero_rd = 1'b0;
        last_rd     = 16'h0;
        bus_data_in = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        cpu_idle();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1) reset state and pass-through
        chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
        chk("rst_active", {31'h0, dma_active}, 32'h0);
        cpu_mem_addr    = 16'h0300;
        cpu_mem_read_en = 1'b1;
        #1;
        chk("pt_rd_addr", {16'h0, bus_addr}, 32'h0300);
        chk("pt_rd_en", {30'h0, bus_read_en, bus_write_en}, 32'h2);
        step();
        cpu_mem_read_en  = 1'b0;
        cpu_mem_write_en = 1'b1;
        cpu_mem_data_out = 8'hAB;
        #1;
        chk("pt_wr", {bus_addr, bus_data_out, 6'h0, bus_read_en, bus_write_en}, {16'h0300, 8'hAB, 8'h01});
        step();
        cpu_idle();
        step();
        chk("pt_mem", {24'h0, mem[16'h0300]}, 32'hAB);

        // 2) page 02, first ALIGN at parity 0
        trigger(8'h02, 0, ea);
        wait_done();
        check_xfer("p0", ea);
        chk("p0_last_rd", {16'h0, last_rd}, 32'h02FF);
        chk("p0_oam_last", {24'h0, mem[16'h2004]}, {24'h0, 8'hFF ^ 8'h5A});

        // 3) same transfer, first ALIGN at parity 1
        trigger(8'h02, 1, ea);
        wait_done();
        check_xfer("p1", ea);

        // 4) page FF: no carry into the page
        trigger(8'hFF, $urandom_range(0, 1), ea);
        wait_done();
        check_xfer("pff", ea);
        chk("pff_last_rd", {16'h0, last_rd}, 32'hFFFF);
        chk("pff_no_zero", {31'h0, saw_zero_rd}, 32'h0);

        // 5) reset on the 100th WRITE
        trigger(8'h02, 0, ea);
        begin
            int n;
            n = 0;
            while (!(dma_active && bus_write_en && wr_cnt == 99) && n < 400) begin step(); n++; end
            chk("rst_reach_w100", {31'h0, bus_write_en}, 32'h1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_wr_cnt", wr_cnt, 100);
        chk("abort_stall", {31'h0, cpu_stall}, 32'h0);
        chk("abort_active", {31'h0, dma_active}, 32'h0);
        exp_q.delete();
        exp_addr_q.delete();
        cpu_mem_addr    = 16'h1234;
        cpu_mem_read_en = 1'b1;
        #1;
        chk("abort_pt", {bus_addr, 6'h0, bus_read_en, bus_write_en}, {16'h1234, 8'h02});
        step();
        cpu_idle();
        trigger(8'h02, 1, ea);
        wait_done();
        check_xfer("restart", ea);

        // 6) CPU strobes ignored while stalled, including a retrigger
        trigger(8'h02, 0, ea);
        repeat (50) step();
        cpu_mem_addr     = 16'h4014;
        cpu_mem_data_out = 8'h77;
        cpu_mem_write_en = 1'b1;
        cpu_mem_read_en  = 1'b1;
        repeat ($urandom_range(10, 30)) step();
        cpu_idle();
        wait_done();
        check_xfer("ign", ea);
        chk("ign_reg_mem", {24'h0, mem[16'h4014]}, 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
